note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Consumer end of the note interface driven by the pattern sequencer.
- Issues one-cycle note requests and accepts the returned note (pitch, length, instrument).
- Times each note's duration in frame ticks and runs a simple per-instrument volume decay.
- Drives a downstream tone generator / mixer with pitch, gate and 4-bit volume.

Parameters:
- WAIT_TIMEOUT, 16, clock cycles allowed from o_note_stb to i_note_valid before declaring the sequencer stopped (≥2).
- TO_WIDTH, 5, width of timeout counter; must hold WAIT_TIMEOUT.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_tick  in  1  frame-rate strobe, one cycle wide
- o_note_stb  out  1  next-note request pulse, one cycle wide
- i_note_valid  in  1  note fields valid this cycle
- i_note_pitch  in  6  0 = rest, 1..63 = pitch index
- i_note_len  in  5  duration in ticks; 0 means 32
- i_note_instrument  in  4  decay period in ticks; 0 = sustain
- o_pitch  out  6  latched pitch of current note
- o_gate  out  1  1 while a non-rest note plays
- o_volume  out  4  current envelope level
- o_note_start  out  1  one-cycle pulse on note acceptance
- o_stopped  out  1  sticky; set when request times out

Behaviour:
- Reset: i_clk, i_rst synchronous, active-high. Reset wins over all inputs in the same cycle, including mid-note and mid-wait.
- Reset values: state=IDLE; o_note_stb=0, o_pitch=0, o_gate=0, o_volume=0, o_note_start=0, o_stopped=0; all counters 0.
- State IDLE: on i_tick -> REQUEST. i_note_valid ignored.
- State REQUEST (one cycle):
  - o_note_stb=1 (combinational from state); timeout counter cleared.
  - -> WAIT_NOTE. i_note_valid ignored.
- State WAIT_NOTE:
  - Timeout counter increments each cycle.
  - On i_note_valid:
    - Latch pitch, instrument; remaining = (len==0 ? 32 : len), 6-bit.
    - Decay counter = 0; o_note_start=1 next cycle (registered, one cycle); -> PLAY.
    - pitch!=0: o_gate=1, o_volume=15. pitch==0: o_gate=0, o_volume=0.
  - A coincident i_tick is not counted against the new note.
  - If counter reaches WAIT_TIMEOUT without valid -> STOPPED.
  - Valid on the same cycle the counter reaches WAIT_TIMEOUT is accepted (valid has priority).
- State PLAY: on each i_tick:
  - remaining decrements. If remaining was 1 -> REQUEST; the next note's o_note_stb is asserted the cycle after that tick.
  - Outputs hold their values across the request/wait gap, so the note sounds until the next acceptance.
  - Envelope, instrument I!=0: decay counter increments; when it reaches I it clears and o_volume decrements, saturating at 0.
  - Envelope, instrument I==0: volume holds.
  - Envelope updates on the same ticks as duration counting.
  - i_note_valid in PLAY is ignored.
- State STOPPED:
  - o_stopped=1, o_gate=0, o_volume=0, o_pitch holds. No further o_note_stb.
  - Exit only via i_rst.
- Latency:
  - Tick in IDLE to o_note_stb: 1 cycle.
  - i_note_valid to outputs updated: 1 cycle.
  - Note length L: exactly L (or 32) ticks from acceptance to the next request.
- Invariants:
  - At most one outstanding request.
  - o_note_stb never asserted in consecutive cycles.
  - o_gate=0 whenever o_pitch==0.

Test Plan:
- Startup: reset, i_tick at cycle 10 -> o_note_stb only at cycle 11. Valid at cycle 15 with pitch=24, len=3, instr=0 -> cycle 16: o_pitch=24, o_gate=1, o_volume=15, o_note_start=1.
- Duration: after note len=3, three i_ticks -> o_note_stb exactly 1 cycle after the 3rd tick, none earlier. Volume stays 15 (sustain).
- Decay and length wrap: pitch=10, len=0, instr=2 -> 32 ticks before request. Volume decrements every 2nd tick 15->0 by tick 30, then saturates at 0.
- Rest: pitch=0, len=2 -> o_gate=0, o_volume=0 throughout. Request after 2 ticks.
- Timeout: o_note_stb with no i_note_valid for 16 cycles -> o_stopped=1, gate/volume 0. Later ticks and valids produce no o_note_stb until reset.
- Simultaneity and mid-op reset:
  - i_tick coincident with i_note_valid -> tick not counted (len=1 request follows the next tick).
  - i_rst asserted in PLAY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/note_player.sv
// Note consumer: requests notes from the sequencer, times their duration in frame ticks,
// applies a per-instrument volume decay and drives pitch/gate/volume to the tone generator.
module note_player #(
  parameter int WAIT_TIMEOUT = 16,
  parameter int TO_WIDTH     = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  output logic       o_note_stb,
  input  logic       i_note_valid,
  input  logic [5:0] i_note_pitch,
  input  logic [4:0] i_note_len,
  input  logic [3:0] i_note_instrument,
  output logic [5:0] o_pitch,
  output logic       o_gate,
  output logic [3:0] o_volume,
  output logic       o_note_start,
  output logic       o_stopped
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQUEST   = 3'd1,
    WAIT_NOTE = 3'd2,
    PLAY      = 3'd3,
    STOPPED   = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [TO_WIDTH-1:0] to_cnt, to_cnt_nx;
  logic [5:0]          remaining, remaining_nx;
  logic [3:0]          instr, instr_nx;
  logic [3:0]          decay_cnt, decay_cnt_nx;
  logic [5:0]          pitch_nx;
  logic                gate_nx;
  logic [3:0]          volume_nx;
  logic                start_nx;
  logic                stopped_nx;

  assign o_note_stb = (state == REQUEST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      remaining    <= '0;
      instr        <= '0;
      decay_cnt    <= '0;
      o_pitch      <= '0;
      o_gate       <= 1'b0;
      o_volume     <= '0;
      o_note_start <= 1'b0;
      o_stopped    <= 1'b0;
    end else begin
      state        <= state_nx;
      to_cnt       <= to_cnt_nx;
      remaining    <= remaining_nx;
      instr        <= instr_nx;
      decay_cnt    <= decay_cnt_nx;
      o_pitch      <= pitch_nx;
      o_gate       <= gate_nx;
      o_volume     <= volume_nx;
      o_note_start <= start_nx;
      o_stopped    <= stopped_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    to_cnt_nx    = to_cnt;
    remaining_nx = remaining;
    instr_nx     = instr;
    decay_cnt_nx = decay_cnt;
    pitch_nx     = o_pitch;
    gate_nx      = o_gate;
    volume_nx    = o_volume;
    start_nx     = 1'b0;
    stopped_nx   = o_stopped;

    case (state)
      IDLE: begin
        if (i_tick) state_nx = REQUEST;
      end

      REQUEST: begin
        to_cnt_nx = '0;
        state_nx  = WAIT_NOTE;
      end

      WAIT_NOTE: begin
        to_cnt_nx = to_cnt + TO_WIDTH'(1);
        // A note arriving on the timeout cycle still wins.
        if (i_note_valid) begin
          pitch_nx     = i_note_pitch;
          instr_nx     = i_note_instrument;
          remaining_nx = (i_note_len == 5'd0) ? 6'd32 : {1'b0, i_note_len};
          decay_cnt_nx = '0;
          start_nx     = 1'b1;
          gate_nx      = (i_note_pitch != 6'd0);
          volume_nx    = (i_note_pitch != 6'd0) ? 4'd15 : 4'd0;
          state_nx     = PLAY;
        end else if (to_cnt_nx == TO_WIDTH'(WAIT_TIMEOUT)) begin
          stopped_nx = 1'b1;
          gate_nx    = 1'b0;
          volume_nx  = '0;
          state_nx   = STOPPED;
        end
      end

      PLAY: begin
        if (i_tick) begin
          remaining_nx = remaining - 6'd1;
          if (remaining == 6'd1) state_nx = REQUEST;
          if (instr != 4'd0) begin
            if (decay_cnt + 4'd1 == instr) begin
              decay_cnt_nx = '0;
              if (o_volume != 4'd0) volume_nx = o_volume - 4'd1;
            end else begin
              decay_cnt_nx = decay_cnt + 4'd1;
            end
          end
        end
      end

      STOPPED: begin
        gate_nx   = 1'b0;
        volume_nx = '0;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_note_player.sv
// Randomized bench for note_player: a transaction-level model (ticks into note, cycles since
// request, closed-form envelope) predicts every output each cycle.
module tb_note_player;

  localparam int WAIT_TIMEOUT = 16;
  localparam int NCYCLES      = 30000;

  logic       i_clk;
  logic       i_rst;
  logic       i_tick;
  logic       o_note_stb;
  logic       i_note_valid;
  logic [5:0] i_note_pitch;
  logic [4:0] i_note_len;
  logic [3:0] i_note_instrument;
  logic [5:0] o_pitch;
  logic       o_gate;
  logic [3:0] o_volume;
  logic       o_note_start;
  logic       o_stopped;

  note_player #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .TO_WIDTH(5)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_tick            (i_tick),
    .o_note_stb        (o_note_stb),
    .i_note_valid      (i_note_valid),
    .i_note_pitch      (i_note_pitch),
    .i_note_len        (i_note_len),
    .i_note_instrument (i_note_instrument),
    .o_pitch           (o_pitch),
    .o_gate            (o_gate),
    .o_volume          (o_volume),
    .o_note_start      (o_note_start),
    .o_stopped         (o_stopped)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  // Model: a request pulse is pending, or we count cycles since the request,
  // or a note is playing with some ticks left, or we are stopped for good.
  bit m_req_now, m_playing, m_stopped, m_start;
  int m_wait;      // cycles since request pulse; 0 = not waiting
  int m_delay;     // planned cycle (after request) on which the bench answers
  int m_left;      // ticks remaining in current note
  int m_ticks;     // ticks counted since acceptance
  int m_pitch, m_instr;

  function automatic int exp_volume();
    int v;
    if (m_stopped || m_pitch == 0) return 0;
    if (m_instr == 0) return 15;
    v = 15 - (m_ticks / m_instr);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_reset();
    m_req_now = 0; m_playing = 0; m_stopped = 0; m_start = 0;
    m_wait = 0; m_delay = 1; m_left = 0; m_ticks = 0; m_pitch = 0; m_instr = 0;
  endtask

  task automatic plan_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0)      m_delay = WAIT_TIMEOUT;
    else if (r == 1) m_delay = WAIT_TIMEOUT + 1;
    else if (r == 2) m_delay = WAIT_TIMEOUT - 1;
    else             m_delay = $urandom_range(1, 6);
  endtask

  task automatic model_step(input bit rst, input bit tick, input bit vld,
                            input int p, input int l, input int ins);
    bit start_n;
    start_n = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_stopped) begin
      // sticky until reset
    end else if (m_req_now) begin
      m_req_now = 0;
      m_wait    = 1;
    end else if (m_wait > 0) begin
      if (vld) begin
        m_pitch   = p;
        m_instr   = ins;
        m_left    = (l == 0) ? 32 : l;
        m_ticks   = 0;
        m_playing = 1;
        m_wait    = 0;
        start_n   = 1;
      end else if (m_wait == WAIT_TIMEOUT) begin
        m_stopped = 1;
        m_wait    = 0;
      end else begin
        m_wait++;
      end
    end else if (m_playing) begin
      if (tick) begin
        m_ticks++;
        m_left--;
        if (m_left == 0) begin
          m_playing = 0;
          m_req_now = 1;
          plan_delay();
        end
      end
    end else if (tick) begin
      m_req_now = 1;
      plan_delay();
    end
    m_start = start_n;
  endtask

  initial begin
    bit rst, tick, vld;
    int p, l, ins;

    i_rst = 1'b1; i_tick = 1'b0; i_note_valid = 1'b0;
    i_note_pitch = '0; i_note_len = '0; i_note_instrument = '0;
    model_reset();

    for (int cyc = 0; cyc < NCYCLES; cyc++) begin
      @(negedge i_clk);
      check("note_stb",   32'(o_note_stb),   32'(m_req_now));
      check("pitch",      32'(o_pitch),      32'(m_pitch));
      check("gate",       32'(o_gate),       32'(!m_stopped && m_pitch != 0));
      check("volume",     32'(o_volume),     32'(exp_volume()));
      check("note_start", 32'(o_note_start), 32'(m_start));
      check("stopped",    32'(o_stopped),    32'(m_stopped));

      rst  = (cyc < 2) || ($urandom_range(0, 399) == 0) ||
             (m_stopped && $urandom_range(0, 29) == 0);
      tick = ($urandom_range(0, 2) == 0);
      if (m_wait > 0) vld = (m_wait == m_delay);
      else            vld = ($urandom_range(0, 7) == 0);
      p   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
      l   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      ins = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);

      i_rst             = rst;
      i_tick            = tick;
      i_note_valid      = vld;
      i_note_pitch      = 6'(p);
      i_note_len        = 5'(l);
      i_note_instrument = 4'(ins);
      model_step(rst, tick, vld, p, l, ins);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
